// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: MEM-stage FSM encoding, default data width
// and the poison value returned when a memory access times out.
package mips_pkg;

  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [31:0] DEAD_DATA = 32'hDEAD_BEEF;

  function automatic logic [1:0] next_state(input logic [1:0] state, input logic acc,
                                            input logic finish);
    logic [1:0] nxt;
    nxt = IDLE;
    case (state)
      IDLE:    nxt = acc ? BUSY : IDLE;
      BUSY:    nxt = finish ? DONE : BUSY;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// BUSY-cycle counter for the MEM stage; flags expiry on the last allowed cycle
// when the memory has not answered.
module mem_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A same-cycle ready always beats the timeout.
  assign expire = busy & ~ready & (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_stage_controller.sv
// MEM-stage sequencer: turns the EX/MEM access into a req/ready memory transaction,
// stalls the pipeline until it completes. Optional watchdog: define MEM_TIMEOUT_EN.
module mem_stage_controller
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              StallM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              MisalignM,
  output logic              MemErrM
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic              we_q, misalign_q;
  logic              access, acc, mis, start, busy, expire;

  assign access = MemReadM | MemWriteM;
  assign acc    = access & (ALUOutM[1:0] == 2'b00);
  assign mis    = access & (ALUOutM[1:0] != 2'b00);
  assign start  = (state_q == IDLE) & acc;
  assign busy   = (state_q == BUSY);

`ifdef MEM_TIMEOUT_EN
  logic memerr_q;

  mem_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .ready (mem_ready),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (reset) memerr_q <= 1'b0;
    else       memerr_q <= expire;
  end

  assign MemErrM = memerr_q;
`else
  assign expire  = 1'b0;
  assign MemErrM = 1'b0;
`endif

  always_comb begin
    state_d = next_state(state_q, acc, mem_ready | expire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Only IDLE sees a fresh instruction; BUSY/DONE hold the one being serviced.
      misalign_q <= (state_q == IDLE) & mis;
      if (start) begin
        addr_q  <= {ALUOutM[DATA_W-1:2], 2'b00};
        wdata_q <= WriteDataM;
        we_q    <= MemWriteM;
      end
      if (busy) begin
        if (mem_ready) begin
          if (!we_q) rdata_q <= mem_rdata;
        end else if (expire) begin
          rdata_q <= DATA_W'(DEAD_DATA);
        end
      end
    end
  end

  assign mem_req   = busy;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ReadDataM = rdata_q;
  assign MisalignM = misalign_q;
  assign StallM    = ~reset & (busy | start);

endmodule

// File: tb/tb_mem_stage_controller.sv
// Self-checking bench for mem_stage_controller: directed vector table, hand sequences for
// reset/timeout corners, then randomized accesses against a transaction-level model.
module tb_mem_stage_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, mem_ready;
  logic [31:0] ALUOutM, WriteDataM, mem_rdata;
  logic        mem_req, mem_we, StallM, MisalignM, MemErrM;
  logic [31:0] mem_addr, mem_wdata, ReadDataM;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  mem_stage_controller #(
    .DATA_W     (32),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemReadM  (MemReadM),
    .MemWriteM (MemWriteM),
    .ALUOutM   (ALUOutM),
    .WriteDataM(WriteDataM),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .StallM    (StallM),
    .ReadDataM (ReadDataM),
    .MisalignM (MisalignM),
    .MemErrM   (MemErrM)
  );

  typedef struct {
    logic        rd, wr, rdy;
    logic [31:0] addr, wdata, rdata;
    logic        e_stall, e_req, e_we, e_mis;
    logic [31:0] e_maddr, e_mwdata, e_rdout;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                              logic rdy, logic [31:0] rdata, logic e_stall, logic e_req,
                              logic e_we, logic [31:0] e_maddr, logic [31:0] e_mwdata,
                              logic e_mis, logic [31:0] e_rdout);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdy = rdy; v.rdata = rdata;
    v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we; v.e_maddr = e_maddr;
    v.e_mwdata = e_mwdata; v.e_mis = e_mis; v.e_rdout = e_rdout;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
    MemReadM = rd; MemWriteM = wr; ALUOutM = addr; WriteDataM = wdata;
  endtask

  // One aligned access; memory answers on the lat-th BUSY cycle.
  task automatic run_acc(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input logic [31:0] rdata);
    int  stall_cnt = 0;
    int  req_cnt   = 0;
    bit  done      = 0;
    if (rd && !wr) exp_rd = rdata;
    drive(rd, wr, addr, wdata);
    for (int k = 0; k < 40 && !done; k++) begin
      mem_ready = (req_cnt == lat - 1);
      mem_rdata = rdata;
      #3;
      if (StallM) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        chk("acc_addr", mem_addr, addr);
        chk("acc_we", mem_we, wr);
        if (wr) chk("acc_wdata", mem_wdata, wdata);
      end
      if (!StallM) begin
        done = 1;
        chk("acc_rdout", ReadDataM, exp_rd);
        chk("acc_memerr", MemErrM, 0);
      end
      step();
    end
    mem_ready = 0;
    chk("acc_done", done, 1);
    chk("acc_stall_cycles", stall_cnt, lat + 1);
    chk("acc_req_cycles", req_cnt, lat);
  endtask

  task automatic mis_acc(input logic rd, input logic wr, input logic [31:0] addr);
    drive(rd, wr, addr, $urandom);
    mem_ready = 0;
    #3;
    chk("mis_stall", StallM, 0);
    chk("mis_req", mem_req, 0);
    step();
    drive(0, 0, 0, 0);
    #3;
    chk("mis_pulse", MisalignM, 1);
    chk("mis_stall2", StallM, 0);
    chk("mis_req2", mem_req, 0);
    step();
  endtask

  task automatic bubble();
    drive(0, 0, $urandom, $urandom);
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    #3;
    chk("idle_stall", StallM, 0);
    chk("idle_req", mem_req, 0);
    chk("idle_mis", MisalignM, 0);
    chk("idle_rdout", ReadDataM, exp_rd);
    step();
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 32'h10, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 32'h10, 0, 1, 32'h1234_5678, 1, 1, 0, 32'h10, 0, 0, 0);
    vecs[2]  = mk(1, 0, 32'h10, 0, 0, 0,            0, 0, 0, 0, 0, 0, 32'h1234_5678);
    vecs[3]  = mk(1, 0, 32'h40, 0, 0, 0,            1, 0, 0, 0, 0, 0, 32'h1234_5678);
    vecs[4]  = mk(1, 0, 32'h40, 0, 1, 32'hAAAA_0001, 1, 1, 0, 32'h40, 0, 0, 32'h1234_5678);
    vecs[5]  = mk(1, 0, 32'h40, 0, 0, 0,            0, 0, 0, 0, 0, 0, 32'hAAAA_0001);
    vecs[6]  = mk(1, 0, 32'h44, 0, 0, 0,            1, 0, 0, 0, 0, 0, 32'hAAAA_0001);
    vecs[7]  = mk(1, 0, 32'h44, 0, 1, 32'hBBBB_0002, 1, 1, 0, 32'h44, 0, 0, 32'hAAAA_0001);
    vecs[8]  = mk(1, 0, 32'h44, 0, 0, 0,            0, 0, 0, 0, 0, 0, 32'hBBBB_0002);
    vecs[9]  = mk(1, 0, 32'h13, 0, 0, 0,            0, 0, 0, 0, 0, 0, 32'hBBBB_0002);
    vecs[10] = mk(0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 32'hBBBB_0002);
    vecs[11] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFF,     0, 0, 0, 0, 0, 0, 32'hBBBB_0002);
    vecs[12] = mk(0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 32'hBBBB_0002);
    vecs[13] = mk(1, 1, 32'h80, 32'h55, 0, 0,       1, 0, 0, 0, 0, 0, 32'hBBBB_0002);
    vecs[14] = mk(1, 1, 32'h80, 32'h55, 1, 32'h7777_7777,
                  1, 1, 1, 32'h80, 32'h55, 0, 32'hBBBB_0002);
    vecs[15] = mk(1, 1, 32'h80, 32'h55, 0, 0,       0, 0, 0, 0, 0, 0, 32'hBBBB_0002);
    vecs[16] = mk(0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 32'hBBBB_0002);

    // Reset: an aligned load present during reset must not stall.
    reset = 1; mem_ready = 0; mem_rdata = 0;
    drive(1, 0, 32'h10, 0);
    step();
    #3;
    chk("stall_in_reset", StallM, 0);
    step();
    reset = 0;
    drive(0, 0, 0, 0);
    #3;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_stall", StallM, 0);
    chk("rst_rdout", ReadDataM, 0);
    chk("rst_mis", MisalignM, 0);
    chk("rst_memerr", MemErrM, 0);
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      mem_ready = vecs[i].rdy;
      mem_rdata = vecs[i].rdata;
      #3;
      chk($sformatf("vec%0d_stall", i), StallM, vecs[i].e_stall);
      chk($sformatf("vec%0d_req", i), mem_req, vecs[i].e_req);
      chk($sformatf("vec%0d_mis", i), MisalignM, vecs[i].e_mis);
      chk($sformatf("vec%0d_rdout", i), ReadDataM, vecs[i].e_rdout);
      chk($sformatf("vec%0d_memerr", i), MemErrM, 0);
      if (vecs[i].e_req) begin
        chk($sformatf("vec%0d_maddr", i), mem_addr, vecs[i].e_maddr);
        chk($sformatf("vec%0d_we", i), mem_we, vecs[i].e_we);
        chk($sformatf("vec%0d_mwdata", i), mem_wdata, vecs[i].e_mwdata);
      end
      step();
    end
    exp_rd = 32'hBBBB_0002;

    // Store with a slow memory: 4 BUSY cycles, read data untouched.
    run_acc(0, 1, 32'h20, 32'hCAFE_F00D, 4, 32'h5A5A_5A5A);

    // Reset arriving mid-BUSY drops the request and discards the response.
    drive(1, 0, 32'h200, 0);
    mem_ready = 0;
    #3;
    chk("rb_stall_idle", StallM, 1);
    step();
    reset = 1; mem_ready = 1; mem_rdata = 32'h9999_9999;
    #3;
    chk("rb_stall_reset", StallM, 0);
    step();
    reset = 0; mem_ready = 0;
    drive(0, 0, 0, 0);
    #3;
    chk("rb_req", mem_req, 0);
    chk("rb_stall", StallM, 0);
    chk("rb_rdout", ReadDataM, 0);
    step();
    exp_rd = 0;

`ifdef MEM_TIMEOUT_EN
    begin
      int  stall_cnt = 0;
      bit  done      = 0;
      drive(1, 0, 32'h300, 0);
      mem_ready = 0;
      for (int k = 0; k < 30 && !done; k++) begin
        #3;
        if (StallM) stall_cnt++;
        else begin
          done = 1;
          chk("to_memerr", MemErrM, 1);
          chk("to_rdout", ReadDataM, 32'hDEAD_BEEF);
          chk("to_req", mem_req, 0);
        end
        step();
      end
      chk("to_done", done, 1);
      chk("to_stall_cycles", stall_cnt, 9);
      drive(0, 0, 0, 0);
      #3;
      chk("to_memerr_pulse", MemErrM, 0);
      chk("to_resume", StallM, 0);
      step();
      exp_rd = 32'hDEAD_BEEF;
      // Ready on the final allowed cycle beats the watchdog.
      run_acc(1, 0, 32'h304, 0, 8, 32'h0BAD_F00D);
    end
`endif

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: bubble();
        1: run_acc(1, 0, $urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(1, 5), $urandom);
        2: run_acc(0, 1, $urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(1, 5), $urandom);
        3: run_acc(1, 1, $urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(1, 5), $urandom);
        default: mis_acc(1'($urandom), 1'b1, ($urandom & 32'hFFFF_FFFC) | $urandom_range(1, 3));
      endcase
    end
    bubble();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
